// File: rtl/cdb_arbiter_if.sv
// Bundle of the two producer channels (ALU, LSB) and the common data bus
// broadcast. The producer/consumer side uses the master modport, the
// arbiter uses the slave modport.
interface cdb_arbiter_if #(
  parameter int DATA_W    = 32,
  parameter int ROB_IDX_W = 4
) ();

  logic                 alu_valid;
  logic [ROB_IDX_W-1:0] alu_rob_index;
  logic [DATA_W-1:0]    alu_result;
  logic                 alu_full;

  logic                 lsb_valid;
  logic [ROB_IDX_W-1:0] lsb_rob_index;
  logic [DATA_W-1:0]    lsb_result;
  logic                 lsb_full;

  logic                 cdb_valid;
  logic [ROB_IDX_W-1:0] cdb_rob_index;
  logic [DATA_W-1:0]    cdb_result;
  logic                 cdb_src;
  logic                 overflow_err;

  modport master (
    output alu_valid, alu_rob_index, alu_result,
    input  alu_full,
    output lsb_valid, lsb_rob_index, lsb_result,
    input  lsb_full,
    input  cdb_valid, cdb_rob_index, cdb_result, cdb_src, overflow_err
  );

  modport slave (
    input  alu_valid, alu_rob_index, alu_result,
    output alu_full,
    input  lsb_valid, lsb_rob_index, lsb_result,
    output lsb_full,
    output cdb_valid, cdb_rob_index, cdb_result, cdb_src, overflow_err
  );

endinterface

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter. Each source (0 = ALU, 1 = LSB) has a private FIFO;
// one result per cycle is granted onto the registered CDB, round-robin when
// both sources have a candidate. An empty FIFO lets the incoming result
// bypass straight to the grant so an uncontended result takes one cycle.
module cdb_arbiter #(
  parameter int DATA_W    = 32,
  parameter int ROB_IDX_W = 4,
  parameter int DEPTH     = 4
) (
  input  logic         clk_in,
  input  logic         rst_n_in,
  input  logic         rdy_in,
  input  logic         clr_in,
  cdb_arbiter_if.slave bus
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  // Per-source views of the inputs, index 0 = ALU, 1 = LSB
  logic [1:0]                in_valid;
  logic [1:0][ROB_IDX_W-1:0] in_idx;
  logic [1:0][DATA_W-1:0]    in_data;

  // FIFO storage and bookkeeping
  logic [ROB_IDX_W-1:0]  idx_mem_q  [2][DEPTH];
  logic [DATA_W-1:0]     data_mem_q [2][DEPTH];
  logic [1:0][PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [1:0][PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [1:0][CNT_W-1:0] cnt_q, cnt_d;

  // Arbitration and broadcast state
  logic                 rr_ptr_q, rr_ptr_d;
  logic                 cdb_valid_q, cdb_valid_d;
  logic [ROB_IDX_W-1:0] cdb_idx_q, cdb_idx_d;
  logic [DATA_W-1:0]    cdb_data_q, cdb_data_d;
  logic                 cdb_src_q, cdb_src_d;
  logic                 ovf_q, ovf_d;

  // Per-cycle decisions
  logic [1:0]                full;
  logic [1:0]                has_head;
  logic [1:0]                acc;
  logic [1:0]                ovf_hit;
  logic [1:0]                cand;
  logic [1:0][ROB_IDX_W-1:0] cand_idx;
  logic [1:0][DATA_W-1:0]    cand_data;
  logic [1:0]                gnt;
  logic [1:0]                pop;
  logic [1:0]                push;
  logic                      contended;
  logic                      gnt_src;

  // Gather the two producer channels into indexable form
  always_comb begin
    in_valid   = {bus.lsb_valid, bus.alu_valid};
    in_idx[0]  = bus.alu_rob_index;
    in_idx[1]  = bus.lsb_rob_index;
    in_data[0] = bus.alu_result;
    in_data[1] = bus.lsb_result;
  end

  // Acceptance, overflow detection and candidate selection per source
  always_comb begin
    full      = '0;
    has_head  = '0;
    acc       = '0;
    ovf_hit   = '0;
    cand      = '0;
    cand_idx  = '0;
    cand_data = '0;
    for (int s = 0; s < 2; s++) begin
      // full comes from the registered count only; a same-cycle pop does not free a slot
      full[s]     = (cnt_q[s] == FULL_CNT);
      has_head[s] = (cnt_q[s] != '0);
      acc[s]      = in_valid[s] && (in_idx[s] != '0) && !full[s] && rdy_in && !clr_in;
      ovf_hit[s]  = in_valid[s] && (in_idx[s] != '0) && full[s] && rdy_in && !clr_in;
      cand[s]     = has_head[s] || acc[s];
      if (has_head[s]) begin
        cand_idx[s]  = idx_mem_q[s][rd_ptr_q[s]];
        cand_data[s] = data_mem_q[s][rd_ptr_q[s]];
      end else begin
        cand_idx[s]  = in_idx[s];
        cand_data[s] = in_data[s];
      end
    end
  end

  // Round-robin grant; the bypass path is only taken by an empty FIFO
  always_comb begin
    contended = cand[0] && cand[1];
    gnt       = cand;
    gnt_src   = cand[1];
    if (contended) begin
      gnt     = rr_ptr_q ? 2'b10 : 2'b01;
      gnt_src = rr_ptr_q;
    end
    pop  = gnt & has_head;
    push = acc & ~(gnt & ~has_head);
  end

  // Next-state for FIFO pointers, counts, rr pointer and the CDB registers
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    cnt_d       = cnt_q;
    rr_ptr_d    = rr_ptr_q;
    cdb_valid_d = cdb_valid_q;
    cdb_idx_d   = cdb_idx_q;
    cdb_data_d  = cdb_data_q;
    cdb_src_d   = cdb_src_q;
    ovf_d       = ovf_q | (|ovf_hit);
    if (rdy_in) begin
      if (clr_in) begin
        wr_ptr_d    = '0;
        rd_ptr_d    = '0;
        cnt_d       = '0;
        rr_ptr_d    = 1'b0;
        cdb_valid_d = 1'b0;
      end else begin
        for (int s = 0; s < 2; s++) begin
          if (push[s]) wr_ptr_d[s] = wr_ptr_q[s] + PTR_W'(1);
          if (pop[s])  rd_ptr_d[s] = rd_ptr_q[s] + PTR_W'(1);
          case ({push[s], pop[s]})
            2'b10:   cnt_d[s] = cnt_q[s] + CNT_W'(1);
            2'b01:   cnt_d[s] = cnt_q[s] - CNT_W'(1);
            default: cnt_d[s] = cnt_q[s];
          endcase
        end
        if (contended) rr_ptr_d = ~rr_ptr_q;
        cdb_valid_d = |cand;
        if (|cand) begin
          cdb_idx_d  = cand_idx[gnt_src];
          cdb_data_d = cand_data[gnt_src];
          cdb_src_d  = gnt_src;
        end
      end
    end
  end

  // Control and broadcast registers, cleared asynchronously
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      rr_ptr_q    <= 1'b0;
      cdb_valid_q <= 1'b0;
      cdb_idx_q   <= '0;
      cdb_data_q  <= '0;
      cdb_src_q   <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      rr_ptr_q    <= rr_ptr_d;
      cdb_valid_q <= cdb_valid_d;
      cdb_idx_q   <= cdb_idx_d;
      cdb_data_q  <= cdb_data_d;
      cdb_src_q   <= cdb_src_d;
      ovf_q       <= ovf_d;
    end
  end

  // FIFO storage write; contents are don't-care while the count is zero
  always_ff @(posedge clk_in) begin
    for (int s = 0; s < 2; s++) begin
      if (push[s]) begin
        idx_mem_q[s][wr_ptr_q[s]]  <= in_idx[s];
        data_mem_q[s][wr_ptr_q[s]] <= in_data[s];
      end
    end
  end

  assign bus.alu_full      = full[0];
  assign bus.lsb_full      = full[1];
  assign bus.cdb_valid     = cdb_valid_q;
  assign bus.cdb_rob_index = cdb_idx_q;
  assign bus.cdb_result    = cdb_data_q;
  assign bus.cdb_src       = cdb_src_q;
  assign bus.overflow_err  = ovf_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Testbench for cdb_arbiter: directed scenarios plus a per-source scoreboard
// that checks every CDB broadcast against the results the producers issued.
module tb_cdb_arbiter;

  localparam int DATA_W    = 32;
  localparam int ROB_IDX_W = 4;
  localparam int DEPTH     = 4;

  logic clk;
  logic rst_n;
  logic rdy;
  logic clr;

  cdb_arbiter_if #(.DATA_W(DATA_W), .ROB_IDX_W(ROB_IDX_W)) bus ();

  cdb_arbiter #(.DATA_W(DATA_W), .ROB_IDX_W(ROB_IDX_W), .DEPTH(DEPTH)) dut (
    .clk_in   (clk),
    .rst_n_in (rst_n),
    .rdy_in   (rdy),
    .clr_in   (clr),
    .bus      (bus)
  );

  int errors = 0;
  int checks = 0;

  logic [ROB_IDX_W+DATA_W-1:0] alu_q [$];
  logic [ROB_IDX_W+DATA_W-1:0] lsb_q [$];

  logic [ROB_IDX_W-1:0] a_idx;
  logic [ROB_IDX_W-1:0] b_idx;
  int a_sent;
  int b_sent;
  logic edge_rdy = 1'b1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // rdy value seen by the DUT at each rising edge
  always @(posedge clk) edge_rdy <= rdy;

  // Scoreboard: each fresh broadcast must match the oldest outstanding result of its source
  always @(negedge clk) begin
    logic [ROB_IDX_W+DATA_W-1:0] exp_e;
    if (rst_n && edge_rdy && bus.cdb_valid) begin
      checks++;
      if (bus.cdb_src == 1'b0) begin
        if (alu_q.size() == 0) begin
          errors++;
          $display("FAIL sb_alu_extra: got idx=%0d data=%h, expected no ALU broadcast", bus.cdb_rob_index, bus.cdb_result);
        end else begin
          exp_e = alu_q.pop_front();
          if ({bus.cdb_rob_index, bus.cdb_result} !== exp_e) begin
            errors++;
            $display("FAIL sb_alu_order: got idx=%0d data=%h, expected idx=%0d data=%h",
                     bus.cdb_rob_index, bus.cdb_result, exp_e[DATA_W+:ROB_IDX_W], exp_e[DATA_W-1:0]);
          end
        end
      end else begin
        if (lsb_q.size() == 0) begin
          errors++;
          $display("FAIL sb_lsb_extra: got idx=%0d data=%h, expected no LSB broadcast", bus.cdb_rob_index, bus.cdb_result);
        end else begin
          exp_e = lsb_q.pop_front();
          if ({bus.cdb_rob_index, bus.cdb_result} !== exp_e) begin
            errors++;
            $display("FAIL sb_lsb_order: got idx=%0d data=%h, expected idx=%0d data=%h",
                     bus.cdb_rob_index, bus.cdb_result, exp_e[DATA_W+:ROB_IDX_W], exp_e[DATA_W-1:0]);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.alu_valid     = 1'b0;
    bus.alu_rob_index = '0;
    bus.alu_result    = '0;
    bus.lsb_valid     = 1'b0;
    bus.lsb_rob_index = '0;
    bus.lsb_result    = '0;
  endtask

  task automatic drive_alu(input logic [ROB_IDX_W-1:0] idx, input logic [DATA_W-1:0] d, input bit expect_acc);
    bus.alu_valid     = 1'b1;
    bus.alu_rob_index = idx;
    bus.alu_result    = d;
    if (expect_acc) alu_q.push_back({idx, d});
  endtask

  task automatic drive_lsb(input logic [ROB_IDX_W-1:0] idx, input logic [DATA_W-1:0] d, input bit expect_acc);
    bus.lsb_valid     = 1'b1;
    bus.lsb_rob_index = idx;
    bus.lsb_result    = d;
    if (expect_acc) lsb_q.push_back({idx, d});
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    rdy   = 1'b1;
    clr   = 1'b0;
    idle_inputs();
    alu_q.delete();
    lsb_q.delete();
    a_idx  = 4'd1;
    b_idx  = 4'd1;
    a_sent = 0;
    b_sent = 0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
  endtask

  // One cycle of both producers pushing while honouring their full flags
  task automatic fill_step(input int lim);
    if (!bus.alu_full && a_sent < lim) begin
      drive_alu(a_idx, DATA_W'($urandom), 1'b1);
      a_idx = (a_idx == 4'd15) ? 4'd1 : a_idx + 4'd1;
      a_sent++;
    end else bus.alu_valid = 1'b0;
    if (!bus.lsb_full && b_sent < lim) begin
      drive_lsb(b_idx, DATA_W'($urandom), 1'b1);
      b_idx = (b_idx == 4'd15) ? 4'd1 : b_idx + 4'd1;
      b_sent++;
    end else bus.lsb_valid = 1'b0;
    tick();
  endtask

  task automatic fill_until_alu_full(input string name);
    for (int i = 0; i < 12; i++) begin
      if (bus.alu_full) break;
      fill_step(1000);
    end
    checks++;
    if (bus.alu_full !== 1'b1) begin
      errors++;
      $display("FAIL %s_fill: alu_full=%b after 12 cycles, expected 1", name, bus.alu_full);
    end
  endtask

  task automatic drain(input string name);
    idle_inputs();
    for (int i = 0; i < 60; i++) begin
      if (alu_q.size() == 0 && lsb_q.size() == 0) break;
      @(negedge clk);
      #1;
    end
    checks++;
    if (alu_q.size() != 0 || lsb_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: outstanding alu=%0d lsb=%0d, expected 0 0", name, alu_q.size(), lsb_q.size());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    rdy   = 1'b1;
    clr   = 1'b0;
    idle_inputs();
    #2;
    checks++;
    if (bus.cdb_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_valid: cdb_valid=%b expected 0", bus.cdb_valid);
    end
    checks++;
    if ({bus.cdb_rob_index, bus.cdb_result, bus.cdb_src} !== '0) begin
      errors++;
      $display("FAIL reset_bus: idx=%0d data=%h src=%b expected all 0", bus.cdb_rob_index, bus.cdb_result, bus.cdb_src);
    end
    checks++;
    if ({bus.alu_full, bus.lsb_full, bus.overflow_err} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags: alu_full=%b lsb_full=%b ovf=%b expected 000", bus.alu_full, bus.lsb_full, bus.overflow_err);
    end
  endtask

  task automatic test_single();
    do_reset();
    drive_alu(4'd5, 32'hDEADBEEF, 1'b1);
    tick();
    idle_inputs();
    checks++;
    if ({bus.cdb_valid, bus.cdb_rob_index, bus.cdb_result, bus.cdb_src} !== {1'b1, 4'd5, 32'hDEADBEEF, 1'b0}) begin
      errors++;
      $display("FAIL t1_bcast: got v=%b idx=%0d data=%h src=%b, expected v=1 idx=5 data=deadbeef src=0",
               bus.cdb_valid, bus.cdb_rob_index, bus.cdb_result, bus.cdb_src);
    end
    tick();
    checks++;
    if (bus.cdb_valid !== 1'b0) begin
      errors++;
      $display("FAIL t1_idle: cdb_valid=%b expected 0", bus.cdb_valid);
    end
  endtask

  task automatic test_round_robin();
    logic [ROB_IDX_W+DATA_W+1:0] exp_seq [4];
    exp_seq[0] = {1'b0, 4'd3, 32'h11, 1'b1};
    exp_seq[1] = {1'b1, 4'd7, 32'h22, 1'b1};
    exp_seq[2] = {1'b0, 4'd4, 32'h33, 1'b1};
    exp_seq[3] = {1'b1, 4'd8, 32'h44, 1'b1};
    do_reset();
    drive_alu(4'd3, 32'h11, 1'b1);
    drive_lsb(4'd7, 32'h22, 1'b1);
    tick();
    drive_alu(4'd4, 32'h33, 1'b1);
    drive_lsb(4'd8, 32'h44, 1'b1);
    for (int k = 0; k < 4; k++) begin
      if (k == 0) begin
        checks++;
        if ({bus.cdb_src, bus.cdb_rob_index, bus.cdb_result, bus.cdb_valid} !== exp_seq[0]) begin
          errors++;
          $display("FAIL t2_grant0: got src=%b idx=%0d v=%b, expected src=0 idx=3 v=1", bus.cdb_src, bus.cdb_rob_index, bus.cdb_valid);
        end
      end else begin
        tick();
        idle_inputs();
        checks++;
        if ({bus.cdb_src, bus.cdb_rob_index, bus.cdb_result, bus.cdb_valid} !== exp_seq[k]) begin
          errors++;
          $display("FAIL t2_grant%0d: got src=%b idx=%0d v=%b, expected src=%b idx=%0d v=1",
                   k, bus.cdb_src, bus.cdb_rob_index, bus.cdb_valid, exp_seq[k][ROB_IDX_W+DATA_W+1], exp_seq[k][DATA_W+1+:ROB_IDX_W]);
        end
      end
    end
    tick();
    checks++;
    if (bus.cdb_valid !== 1'b0) begin
      errors++;
      $display("FAIL t2_idle: cdb_valid=%b expected 0", bus.cdb_valid);
    end
  endtask

  task automatic test_saturate();
    int a_first = -1;
    int b_first = -1;
    do_reset();
    for (int step = 1; step <= 60; step++) begin
      if (a_sent >= 15 && b_sent >= 15) break;
      fill_step(15);
      if (step <= 8 && bus.alu_full && a_first < 0) a_first = step;
      if (step <= 8 && bus.lsb_full && b_first < 0) b_first = step;
    end
    checks++;
    if (a_first < 0 || b_first < 0) begin
      errors++;
      $display("FAIL t3_full: alu_full first at %0d, lsb_full first at %0d, expected both within 8 cycles", a_first, b_first);
    end
    checks++;
    if (a_sent != 15 || b_sent != 15) begin
      errors++;
      $display("FAIL t3_sent: alu=%0d lsb=%0d issued, expected 15 15", a_sent, b_sent);
    end
    drain("t3");
    checks++;
    if (bus.overflow_err !== 1'b0) begin
      errors++;
      $display("FAIL t3_ovf: overflow_err=%b expected 0", bus.overflow_err);
    end
  endtask

  task automatic test_clear();
    do_reset();
    fill_until_alu_full("t4");
    clr = 1'b1;
    bus.alu_valid = 1'b0;
    drive_lsb(4'd13, 32'hC1, 1'b0);
    tick();
    clr = 1'b0;
    idle_inputs();
    alu_q.delete();
    lsb_q.delete();
    checks++;
    if ({bus.cdb_valid, bus.alu_full, bus.lsb_full} !== 3'b000) begin
      errors++;
      $display("FAIL t4_clr: cdb_valid=%b alu_full=%b lsb_full=%b expected 000", bus.cdb_valid, bus.alu_full, bus.lsb_full);
    end
    tick();
    checks++;
    if (bus.cdb_valid !== 1'b0) begin
      errors++;
      $display("FAIL t4_flushed: cdb_valid=%b expected 0", bus.cdb_valid);
    end
    drive_alu(4'd9, 32'h99, 1'b1);
    tick();
    idle_inputs();
    checks++;
    if ({bus.cdb_valid, bus.cdb_rob_index, bus.cdb_result, bus.cdb_src} !== {1'b1, 4'd9, 32'h99, 1'b0}) begin
      errors++;
      $display("FAIL t4_idx9: got v=%b idx=%0d data=%h src=%b, expected v=1 idx=9 data=99 src=0",
               bus.cdb_valid, bus.cdb_rob_index, bus.cdb_result, bus.cdb_src);
    end
    drive_alu(4'd11, 32'hB1, 1'b1);
    drive_lsb(4'd12, 32'hB2, 1'b1);
    tick();
    idle_inputs();
    checks++;
    if ({bus.cdb_src, bus.cdb_rob_index} !== {1'b0, 4'd11}) begin
      errors++;
      $display("FAIL t4_rr: got src=%b idx=%0d, expected src=0 idx=11", bus.cdb_src, bus.cdb_rob_index);
    end
    drain("t4");
  endtask

  task automatic test_drop_and_overflow();
    do_reset();
    drive_alu(4'd0, 32'h55, 1'b0);
    tick();
    idle_inputs();
    checks++;
    if (bus.cdb_valid !== 1'b0) begin
      errors++;
      $display("FAIL t5_idx0: cdb_valid=%b expected 0", bus.cdb_valid);
    end
    tick();
    checks++;
    if ({bus.cdb_valid, bus.alu_full} !== 2'b00) begin
      errors++;
      $display("FAIL t5_idx0_late: cdb_valid=%b alu_full=%b expected 00", bus.cdb_valid, bus.alu_full);
    end
    fill_until_alu_full("t5");
    checks++;
    if (bus.overflow_err !== 1'b0) begin
      errors++;
      $display("FAIL t5_ovf_pre: overflow_err=%b expected 0", bus.overflow_err);
    end
    bus.lsb_valid = 1'b0;
    drive_alu(4'd14, 32'hEE, 1'b0);
    tick();
    idle_inputs();
    checks++;
    if (bus.overflow_err !== 1'b1) begin
      errors++;
      $display("FAIL t5_ovf_set: overflow_err=%b expected 1", bus.overflow_err);
    end
    drain("t5");
    checks++;
    if (bus.overflow_err !== 1'b1) begin
      errors++;
      $display("FAIL t5_ovf_sticky: overflow_err=%b expected 1", bus.overflow_err);
    end
  endtask

  task automatic test_stall_and_async_reset();
    do_reset();
    for (int k = 1; k <= 3; k++) begin
      drive_alu(ROB_IDX_W'(k), DATA_W'(32'hA0 + k), 1'b1);
      drive_lsb(ROB_IDX_W'(k + 8), DATA_W'(32'hB0 + k + 8), 1'b1);
      tick();
    end
    rdy = 1'b0;
    drive_alu(4'd7, 32'h77, 1'b0);
    drive_lsb(4'd6, 32'h66, 1'b0);
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if ({bus.cdb_valid, bus.cdb_rob_index, bus.cdb_result, bus.cdb_src, bus.alu_full, bus.lsb_full} !==
          {1'b1, 4'd2, 32'hA2, 1'b0, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL t6_freeze%0d: got v=%b idx=%0d data=%h src=%b, expected v=1 idx=2 data=a2 src=0",
                 k, bus.cdb_valid, bus.cdb_rob_index, bus.cdb_result, bus.cdb_src);
      end
    end
    idle_inputs();
    rdy = 1'b1;
    drain("t6");
    fill_until_alu_full("t6b");
    #3;
    rst_n = 1'b0;
    idle_inputs();
    alu_q.delete();
    lsb_q.delete();
    #1;
    checks++;
    if ({bus.cdb_valid, bus.cdb_rob_index, bus.cdb_result, bus.cdb_src, bus.alu_full, bus.lsb_full, bus.overflow_err} !== '0) begin
      errors++;
      $display("FAIL t6_async_rst: v=%b idx=%0d data=%h src=%b af=%b lf=%b ovf=%b, expected all 0",
               bus.cdb_valid, bus.cdb_rob_index, bus.cdb_result, bus.cdb_src, bus.alu_full, bus.lsb_full, bus.overflow_err);
    end
    #1 rst_n = 1'b1;
    tick();
    checks++;
    if ({bus.cdb_valid, bus.alu_full} !== 2'b00) begin
      errors++;
      $display("FAIL t6_discard: cdb_valid=%b alu_full=%b expected 00", bus.cdb_valid, bus.alu_full);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_saturate();
    test_clear();
    test_drop_and_overflow();
    test_stall_and_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

endmodule
